puf_response_misr: RTL and testbench

PUF_RESPONSE_MISR -- requirements
Module: puf_response_misr

---
 rtl/puf_pkg.sv | 15 +
 rtl/puf_response_misr_if.sv | 22 ++
 rtl/puf_misr_step.sv | 14 +
 rtl/puf_response_misr.sv | 82 ++++++++
 tb/tb_puf_response_misr.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response MISR: FSM state encoding and
// the default feedback polynomial and seed.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } puf_state_e;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] PUF_DEFAULT_POLY = 32'h0040_0007;
  localparam logic [31:0] PUF_DEFAULT_SEED = 32'h0000_0000;

endpackage

// File: rtl/puf_response_misr_if.sv
// Scan-side inputs and response handshake of the PUF MISR.
// The master modport is the compactor; the slave modport is its environment.
interface puf_response_misr_if;
  logic        scan_enable;
  logic        count_done;
  logic        scan_in;
  logic [31:0] resp_data;
  logic [15:0] resp_bits;
  logic        resp_valid;
  logic        resp_ready;
  logic        overrun;

  modport master (
    input  scan_enable, count_done, scan_in, resp_ready,
    output resp_data, resp_bits, resp_valid, overrun
  );

  modport slave (
    output scan_enable, count_done, scan_in, resp_ready,
    input  resp_data, resp_bits, resp_valid, overrun
  );
endinterface

// File: rtl/puf_misr_step.sv
// One combinational MISR step: shift left, fold in the feedback polynomial
// when the MSB falls out, and XOR the new response bit into bit 0.
module puf_misr_step (
  input  logic [31:0] misr,
  input  logic        scan_bit,
  input  logic [31:0] poly,
  output logic [31:0] misr_next
);

  assign misr_next = {misr[30:0], 1'b0}
                   ^ (misr[31] ? poly : 32'h0000_0000)
                   ^ {31'b0, scan_bit};

endmodule

// File: rtl/puf_response_misr.sv
// Compacts a serial PUF response window into a 32-bit MISR signature and
// holds it with a bit count until the consumer takes it.
module puf_response_misr
  import puf_pkg::*;
#(
  parameter logic [31:0] SEED = PUF_DEFAULT_SEED,
  parameter logic [31:0] POLY = PUF_DEFAULT_POLY
) (
  input  logic                       clk,
  input  logic                       rst,
  puf_response_misr_if.master        bus
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_CAPTURE = CAPTURE;
  localparam logic [1:0] S_HOLD    = HOLD;

  logic [1:0]  state_p0;
  logic [31:0] misr_p0;
  logic [15:0] bit_cnt_p0;
  logic        overrun_p0;
  logic [31:0] misr_base;
  logic [31:0] misr_step;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The first bit of a window compacts into SEED rather than the stale signature.
  assign misr_base = (state_p0 == S_IDLE) ? SEED : misr_p0;

  puf_misr_step u_step (
    .misr      (misr_base),
    .scan_bit  (bus.scan_in),
    .poly      (POLY),
    .misr_next (misr_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= S_IDLE;
      misr_p0    <= SEED;
      bit_cnt_p0 <= 16'd0;
      overrun_p0 <= 1'b0;
    end else begin
      case (state_p0)
        S_IDLE: begin
          if (bus.scan_enable) begin
            misr_p0    <= misr_step;
            bit_cnt_p0 <= 16'd1;
            state_p0   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (bus.scan_enable) begin
            misr_p0    <= misr_step;
            bit_cnt_p0 <= sat_inc16(bit_cnt_p0);
          end
          if (bus.count_done) begin
            state_p0 <= S_HOLD;
          end
        end
        S_HOLD: begin
          // A new window arriving while the result is unread is lost, not merged.
          if (bus.scan_enable) begin
            overrun_p0 <= 1'b1;
          end
          if (bus.resp_ready) begin
            state_p0 <= S_IDLE;
          end
        end
        default: state_p0 <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_data  = misr_p0;
  assign bus.resp_bits  = bit_cnt_p0;
  assign bus.resp_valid = (state_p0 == S_HOLD);
  assign bus.overrun    = overrun_p0;

endmodule

// File: tb/tb_puf_response_misr.sv
// Directed bench for puf_response_misr: two instances (SEED=0 and SEED=8000_0000)
// driven through their interfaces, each scenario checking hand-computed values.
module tb_puf_response_misr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  puf_response_misr_if bus0 ();
  puf_response_misr_if bus1 ();

  puf_response_misr #(.SEED(32'h0000_0000), .POLY(32'h0040_0007)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  puf_response_misr #(.SEED(32'h8000_0000), .POLY(32'h0040_0007)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.scan_enable = 1'b0; bus0.count_done = 1'b0; bus0.scan_in = 1'b0; bus0.resp_ready = 1'b0;
    bus1.scan_enable = 1'b0; bus1.count_done = 1'b0; bus1.scan_in = 1'b0; bus1.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", bus0.resp_valid); end
    checks++; if (bus0.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%0b exp=0", bus0.overrun); end
    checks++; if (bus0.resp_data !== 32'h0000_0000) begin fails++; $display("FAIL reset_data0 got=%h exp=00000000", bus0.resp_data); end
    checks++; if (bus0.resp_bits !== 16'd0) begin fails++; $display("FAIL reset_bits got=%0d exp=0", bus0.resp_bits); end
    checks++; if (bus1.resp_data !== 32'h8000_0000) begin fails++; $display("FAIL reset_data1 got=%h exp=80000000", bus1.resp_data); end
  endtask

  task automatic test_basic_capture();
    logic [3:0] pattern;
    pattern = 4'b1101; // sent LSB first: 1,0,1,1
    bus0.scan_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.scan_in = pattern[i];
      tick();
    end
    bus0.scan_enable = 1'b0;
    bus0.scan_in = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early got=%0b exp=0", bus0.resp_valid); end
    bus0.count_done = 1'b1;
    tick();
    bus0.count_done = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b1) begin fails++; $display("FAIL basic_latency got=%0b exp=1", bus0.resp_valid); end
    checks++; if (bus0.resp_data !== 32'h0000_000B) begin fails++; $display("FAIL basic_data got=%h exp=0000000b", bus0.resp_data); end
    checks++; if (bus0.resp_bits !== 16'd4) begin fails++; $display("FAIL basic_bits got=%0d exp=4", bus0.resp_bits); end
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL basic_handshake got=%0b exp=0", bus0.resp_valid); end
  endtask

  task automatic test_feedback();
    bus1.scan_enable = 1'b1;
    bus1.scan_in = 1'b0;
    tick();
    bus1.scan_enable = 1'b0;
    bus1.count_done = 1'b1;
    tick();
    bus1.count_done = 1'b0;
    checks++; if (bus1.resp_valid !== 1'b1) begin fails++; $display("FAIL feedback_valid got=%0b exp=1", bus1.resp_valid); end
    checks++; if (bus1.resp_data !== 32'h0040_0007) begin fails++; $display("FAIL feedback_data got=%h exp=00400007", bus1.resp_data); end
    checks++; if (bus1.resp_bits !== 16'd1) begin fails++; $display("FAIL feedback_bits got=%0d exp=1", bus1.resp_bits); end
    bus1.resp_ready = 1'b1;
    tick();
    bus1.resp_ready = 1'b0;
    checks++; if (bus1.resp_valid !== 1'b0) begin fails++; $display("FAIL feedback_handshake got=%0b exp=0", bus1.resp_valid); end
  endtask

  task automatic test_backpressure();
    bus0.scan_enable = 1'b1;
    bus0.scan_in = 1'b1;
    tick();
    tick();
    bus0.scan_enable = 1'b0;
    bus0.scan_in = 1'b0;
    bus0.count_done = 1'b1;
    tick();
    bus0.count_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus0.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, bus0.resp_valid); end
      checks++; if (bus0.resp_data !== 32'h0000_0003) begin fails++; $display("FAIL bp_data[%0d] got=%h exp=00000003", i, bus0.resp_data); end
      tick();
    end
    bus0.resp_ready = 1'b1;
    tick();
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got=%0b exp=0", bus0.resp_valid); end
    // ready with nothing pending must be harmless
    tick();
    tick();
    bus0.resp_ready = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL idle_ready_valid got=%0b exp=0", bus0.resp_valid); end
    checks++; if (bus0.resp_data !== 32'h0000_0003) begin fails++; $display("FAIL idle_ready_data got=%h exp=00000003", bus0.resp_data); end
  endtask

  task automatic test_overrun();
    bus0.scan_enable = 1'b1;
    bus0.scan_in = 1'b1;
    tick();
    bus0.scan_in = 1'b0;
    tick();
    bus0.scan_enable = 1'b0;
    bus0.count_done = 1'b1;
    tick();
    bus0.count_done = 1'b0;
    checks++; if (bus0.overrun !== 1'b0) begin fails++; $display("FAIL ovr_before got=%0b exp=0", bus0.overrun); end
    bus0.scan_enable = 1'b1;
    bus0.scan_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus0.scan_enable = 1'b0;
    bus0.scan_in = 1'b0;
    checks++; if (bus0.overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got=%0b exp=1", bus0.overrun); end
    checks++; if (bus0.resp_data !== 32'h0000_0002) begin fails++; $display("FAIL ovr_data got=%h exp=00000002", bus0.resp_data); end
    checks++; if (bus0.resp_bits !== 16'd2) begin fails++; $display("FAIL ovr_bits got=%0d exp=2", bus0.resp_bits); end
    checks++; if (bus0.resp_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got=%0b exp=1", bus0.resp_valid); end
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL ovr_handshake got=%0b exp=0", bus0.resp_valid); end
    checks++; if (bus0.overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got=%0b exp=1", bus0.overrun); end
    // dropped window must not restart a capture; count_done in IDLE is ignored too
    bus0.count_done = 1'b1;
    tick();
    bus0.count_done = 1'b0;
    tick();
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL ovr_no_restart got=%0b exp=0", bus0.resp_valid); end
    checks++; if (bus0.resp_bits !== 16'd2) begin fails++; $display("FAIL ovr_bits_hold got=%0d exp=2", bus0.resp_bits); end
  endtask

  task automatic test_same_cycle_end();
    logic [2:0] pattern;
    pattern = 3'b101; // sent LSB first: 1,0,1
    bus0.scan_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus0.scan_in = pattern[i];
      tick();
    end
    bus0.scan_in = 1'b1;
    bus0.count_done = 1'b1;
    tick();
    bus0.scan_enable = 1'b0;
    bus0.scan_in = 1'b0;
    bus0.count_done = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b1) begin fails++; $display("FAIL same_valid got=%0b exp=1", bus0.resp_valid); end
    checks++; if (bus0.resp_data !== 32'h0000_000B) begin fails++; $display("FAIL same_data got=%h exp=0000000b", bus0.resp_data); end
    checks++; if (bus0.resp_bits !== 16'd4) begin fails++; $display("FAIL same_bits got=%0d exp=4", bus0.resp_bits); end
    checks++; if (bus0.overrun !== 1'b1) begin fails++; $display("FAIL same_overrun_kept got=%0b exp=1", bus0.overrun); end
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus0.overrun !== 1'b0) begin fails++; $display("FAIL ovr_cleared_by_rst got=%0b exp=0", bus0.overrun); end
  endtask

  task automatic test_reset_mid_capture();
    bus0.scan_enable = 1'b1;
    bus0.scan_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus0.resp_data !== 32'h0000_001F) begin fails++; $display("FAIL mid_pre_data got=%h exp=0000001f", bus0.resp_data); end
    rst = 1'b1;
    bus0.count_done = 1'b1;
    tick();
    rst = 1'b0;
    bus0.scan_enable = 1'b0;
    bus0.scan_in = 1'b0;
    bus0.count_done = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%0b exp=0", bus0.resp_valid); end
    checks++; if (bus0.resp_data !== 32'h0000_0000) begin fails++; $display("FAIL mid_rst_data got=%h exp=00000000", bus0.resp_data); end
    checks++; if (bus0.resp_bits !== 16'd0) begin fails++; $display("FAIL mid_rst_bits got=%0d exp=0", bus0.resp_bits); end
    // IDLE ignores count_done
    bus0.count_done = 1'b1;
    tick();
    bus0.count_done = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_idle_cd got=%0b exp=0", bus0.resp_valid); end
    bus0.scan_enable = 1'b1;
    bus0.scan_in = 1'b1;
    tick();
    tick();
    bus0.scan_enable = 1'b0;
    bus0.scan_in = 1'b0;
    bus0.count_done = 1'b1;
    tick();
    bus0.count_done = 1'b0;
    checks++; if (bus0.resp_data !== 32'h0000_0003) begin fails++; $display("FAIL mid_next_data got=%h exp=00000003", bus0.resp_data); end
    checks++; if (bus0.resp_bits !== 16'd2) begin fails++; $display("FAIL mid_next_bits got=%0d exp=2", bus0.resp_bits); end
    checks++; if (bus0.resp_valid !== 1'b1) begin fails++; $display("FAIL mid_next_valid got=%0b exp=1", bus0.resp_valid); end
    // reset while a response is pending discards it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus0.resp_valid !== 1'b0) begin fails++; $display("FAIL hold_rst_valid got=%0b exp=0", bus0.resp_valid); end
    checks++; if (bus0.resp_data !== 32'h0000_0000) begin fails++; $display("FAIL hold_rst_data got=%h exp=00000000", bus0.resp_data); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_capture();
    test_feedback();
    test_backpressure();
    test_overrun();
    test_same_cycle_end();
    test_reset_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
